// File: rtl/lsu_pkg.sv
// Shared types and helpers for the misaligned load/store splitter.
package lsu_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned WORD_W         = 32;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BEAT0 = 2'b01,
      BEAT1 = 2'b10,
      DONE  = 2'b11
   } lsu_state_e;

   // Captured request payload (address is held separately, it is ADDR_W wide)
   typedef struct packed {
      logic              we;
      size_e             size;
      logic              uns;
      logic [WORD_W-1:0] wdata;
   } lsu_req_t;

   // Raw size field to size_e; the unused encoding 11 behaves as a word
   function automatic size_e decode_size(input logic [1:0] raw);
      case (raw)
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

   // Byte-lane mask over two consecutive words: [3:0] first word, [7:4] next word
   function automatic logic [7:0] lane_mask8(input size_e sz, input logic [1:0] off);
      logic [3:0] bm;
      case (sz)
         SZ_B:    bm = 4'b0001;
         SZ_H:    bm = 4'b0011;
         default: bm = 4'b1111;
      endcase
      return 8'({4'b0000, bm} << off);
   endfunction

endpackage

// File: rtl/lsu_misalign_split_load_extend.sv
// Merges the low/high load words, shifts the addressed bytes down and extends them.
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [63:0] pair,
   input  logic [1:0]  offset,
   input  size_e       size,
   input  logic        is_unsigned,
   output logic [31:0] result_c
);

   logic [31:0] shifted;

   // Align the first addressed byte to lane 0, then sign/zero extend by size
   always_comb begin
      shifted = 32'(pair >> {offset, 3'b000});
      case (size)
         SZ_B:    result_c = is_unsigned ? {24'h000000, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
         SZ_H:    result_c = is_unsigned ? {16'h0000, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
         default: result_c = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_misalign_split.sv
// Splits one MEM-stage access of any alignment into word-aligned bus beats.
// Optional build macro: MISALIGN_TRAP_EN (word-crossing accesses raise
// misalign_exc_o instead of being split into two beats).
module lsu_misalign_split
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid_i,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              stall_o,
   output logic              mem_valid_o,
   input  logic              mem_ready_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_wmask_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              misalign_exc_o
);

   lsu_state_e          state_q, state_d;
   lsu_req_t            req_q, req_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   lo_q, lo_d;

   logic                mem_valid_d, mem_we_d, rsp_valid_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic [3:0]          mem_wmask_d;
   logic [DATA_W-1:0]   mem_wdata_d, rsp_rdata_d;

   size_e               in_size;
   logic [7:0]          in_m8, q_m8;
   logic                in_cross, q_cross;
   logic [2*DATA_W-1:0] in_lanes, q_lanes;
   logic [2*DATA_W-1:0] ext_pair;
   logic [DATA_W-1:0]   ext_res;

`ifdef MISALIGN_TRAP_EN
   logic                exc_d;
`endif

   // Lane geometry of the incoming request and of the captured request
   assign in_size  = decode_size(req_size_i);
   assign in_m8    = lane_mask8(in_size, req_addr_i[1:0]);
   assign in_cross = |in_m8[7:4];
   assign in_lanes = {DATA_W'(0), req_wdata_i} << {req_addr_i[1:0], 3'b000};
   assign q_m8     = lane_mask8(req_q.size, addr_q[1:0]);
   assign q_cross  = |q_m8[7:4];
   assign q_lanes  = {DATA_W'(0), req_q.wdata} << {addr_q[1:0], 3'b000};

   // Second beat merges with the captured low word; a single beat has no high word
   assign ext_pair = (state_q == BEAT1) ? {mem_rdata_i, lo_q} : {DATA_W'(0), mem_rdata_i};

   lsu_load_extend u_load_extend (
      .pair        (ext_pair),
      .offset      (addr_q[1:0]),
      .size        (req_q.size),
      .is_unsigned (req_q.uns),
      .result_c    (ext_res)
   );

   // Next-state, next-output and pipeline stall decode
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      addr_d      = addr_q;
      lo_d        = lo_q;
      mem_valid_d = mem_valid_o;
      mem_we_d    = mem_we_o;
      mem_addr_d  = mem_addr_o;
      mem_wmask_d = mem_wmask_o;
      mem_wdata_d = mem_wdata_o;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_o;
      stall_o     = 1'b0;
`ifdef MISALIGN_TRAP_EN
      exc_d       = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            stall_o = req_valid_i;
            if (req_valid_i) begin
               req_d.we    = req_we_i;
               req_d.size  = in_size;
               req_d.uns   = req_unsigned_i;
               req_d.wdata = req_wdata_i;
               addr_d      = req_addr_i;
`ifdef MISALIGN_TRAP_EN
               if (in_cross) begin
                  state_d     = DONE;
                  rsp_valid_d = 1'b1;
                  exc_d       = 1'b1;
                  rsp_rdata_d = '0;
               end else
`endif
               begin
                  state_d     = BEAT0;
                  mem_valid_d = 1'b1;
                  mem_we_d    = req_we_i;
                  mem_addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
                  mem_wmask_d = req_we_i ? in_m8[3:0] : 4'b0000;
                  mem_wdata_d = req_we_i ? in_lanes[DATA_W-1:0] : '0;
               end
            end
         end

         BEAT0: begin
            stall_o = 1'b1;
            if (mem_ready_i) begin
               if (q_cross) begin
                  state_d     = BEAT1;
                  lo_d        = mem_rdata_i;
                  mem_addr_d  = mem_addr_o + ADDR_W'(BYTES_PER_WORD);
                  mem_wmask_d = req_q.we ? q_m8[7:4] : 4'b0000;
                  mem_wdata_d = req_q.we ? q_lanes[2*DATA_W-1:DATA_W] : '0;
               end else begin
                  state_d     = DONE;
                  mem_valid_d = 1'b0;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = '0;
                  mem_wmask_d = 4'b0000;
                  mem_wdata_d = '0;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = req_q.we ? '0 : ext_res;
               end
            end
         end

         BEAT1: begin
            stall_o = 1'b1;
            if (mem_ready_i) begin
               state_d     = DONE;
               mem_valid_d = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wmask_d = 4'b0000;
               mem_wdata_d = '0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = req_q.we ? '0 : ext_res;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, captured request and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         req_q       <= '0;
         addr_q      <= '0;
         lo_q        <= '0;
         mem_valid_o <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wmask_o <= 4'b0000;
         mem_wdata_o <= '0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         lo_q        <= lo_d;
         mem_valid_o <= mem_valid_d;
         mem_we_o    <= mem_we_d;
         mem_addr_o  <= mem_addr_d;
         mem_wmask_o <= mem_wmask_d;
         mem_wdata_o <= mem_wdata_d;
         rsp_valid_o <= rsp_valid_d;
         rsp_rdata_o <= rsp_rdata_d;
      end
   end

`ifdef MISALIGN_TRAP_EN
   // Exception pulse, coincident with the trapped response
   always_ff @(posedge clk) begin
      if (!reset_n) misalign_exc_o <= 1'b0;
      else          misalign_exc_o <= exc_d;
   end
`else
   assign misalign_exc_o = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_misalign_split.sv
// Scoreboard bench for lsu_misalign_split: stimulus queues expected beats and
// responses; an independent monitor checks them as the DUT presents them.
module tb_lsu_misalign_split;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid_i, req_we_i, req_unsigned_i;
   logic [1:0]  req_size_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        stall_o, mem_valid_o, mem_we_o, rsp_valid_o, misalign_exc_o;
   logic        mem_ready_i = 1'b1;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, rsp_rdata_o;
   logic [3:0]  mem_wmask_o;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wmask;
      logic [31:0] wdata;
      logic        chk_wdata;
   } beat_t;

   typedef struct {
      logic [31:0] rdata;
      logic        exc;
      int          cyc;
   } rsp_t;

   beat_t beat_q[$];
   rsp_t  rsp_q[$];

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          beat_idx = 0;
   int          hold_beat = 0;
   int          hold_n = 0;
   int          held = 0;
   logic [31:0] rd0 = '0;
   logic [31:0] rd1 = '0;

   lsu_misalign_split dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_valid_i    (req_valid_i),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .stall_o        (stall_o),
      .mem_valid_o    (mem_valid_o),
      .mem_ready_i    (mem_ready_i),
      .mem_we_o       (mem_we_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wmask_o    (mem_wmask_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_rdata_i    (mem_rdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .misalign_exc_o (misalign_exc_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Bus beat counter within the current access selects the read data word
   always @(posedge clk) begin
      if (!reset_n || rsp_valid_o) beat_idx <= 0;
      else if (mem_valid_o && mem_ready_i) beat_idx <= beat_idx + 1;
   end
   assign mem_rdata_i = (beat_idx == 0) ? rd0 : rd1;

   // Bus ready: optionally withheld for hold_n cycles on beat hold_beat
   always @(negedge clk) begin
      if (mem_valid_o && beat_idx == hold_beat && held < hold_n) begin
         mem_ready_i = 1'b0;
         held++;
      end else begin
         mem_ready_i = 1'b1;
         if (!mem_valid_o) held = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_beat(input logic [31:0] a, input logic we, input logic [3:0] m,
                            input logic [31:0] d, input logic chkw);
      beat_t b;
      b.addr = a; b.we = we; b.wmask = m; b.wdata = d; b.chk_wdata = chkw;
      beat_q.push_back(b);
   endtask

   // Present one request, hold it while stalled, then return to an idle cycle
   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] r0, input logic [31:0] r1,
                        input logic [31:0] exp_rdata, input logic exp_exc, input int lat);
      rsp_t r;
      bit   done = 0;
      @(negedge clk);
      rd0 = r0; rd1 = r1;
      req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
      req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
      r.rdata = exp_rdata; r.exc = exp_exc; r.cyc = cyc + lat;
      rsp_q.push_back(r);
      #1 chk("stall_on_request", 32'(stall_o), 32'd1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!stall_o) begin done = 1; break; end
      end
      if (!done) chk("stall_release_timeout", 32'd0, 32'd1);
      req_valid_i = 1'b0;
      @(negedge clk);
   endtask

   // Monitor: compares every presented beat and every response against the queues
   initial begin
      beat_t b;
      rsp_t  r;
      forever begin
         @(negedge clk);
         #1;
         if (reset_n === 1'b1) begin
            if (mem_valid_o) begin
               if (beat_q.size() == 0) begin
                  chk("unexpected_beat_addr", mem_addr_o, 32'hXXXX_XXXX);
               end else begin
                  b = beat_q[0];
                  chk("beat_addr", mem_addr_o, b.addr);
                  chk("beat_we", 32'(mem_we_o), 32'(b.we));
                  chk("beat_wmask", 32'(mem_wmask_o), 32'(b.wmask));
                  if (b.chk_wdata) chk("beat_wdata", mem_wdata_o, b.wdata);
                  chk("stall_in_beat", 32'(stall_o), 32'd1);
                  if (mem_ready_i) void'(beat_q.pop_front());
               end
            end
            if (rsp_valid_o) begin
               if (rsp_q.size() == 0) begin
                  chk("unexpected_rsp", rsp_rdata_o, 32'hXXXX_XXXX);
               end else begin
                  r = rsp_q.pop_front();
                  chk("rsp_rdata", rsp_rdata_o, r.rdata);
                  chk("rsp_exc", 32'(misalign_exc_o), 32'(r.exc));
                  chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
                  chk("stall_in_done", 32'(stall_o), 32'd0);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      n_bad++;
      $display("FAIL watchdog: simulation did not complete");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      reset_n = 1'b0;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
      req_addr_i = '0; req_wdata_i = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_mem_valid", 32'(mem_valid_o), 32'd0);
      chk("reset_stall", 32'(stall_o), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("reset_exc", 32'(misalign_exc_o), 32'd0);
      chk("reset_mem_addr", mem_addr_o, 32'd0);
      chk("reset_rsp_rdata", rsp_rdata_o, 32'd0);
      chk("reset_wmask", 32'(mem_wmask_o), 32'd0);
      reset_n = 1'b1;

      // Aligned word load
      push_beat(32'h100, 1'b0, 4'b0000, 32'h0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 2);

      // Byte loads, signed and unsigned
      push_beat(32'h300, 1'b0, 4'b0000, 32'h0, 1'b0);
      issue(1'b0, 2'b00, 1'b0, 32'h302, 32'h0, 32'h00A50000, 32'h0, 32'hFFFFFFA5, 1'b0, 2);
      push_beat(32'h300, 1'b0, 4'b0000, 32'h0, 1'b0);
      issue(1'b0, 2'b00, 1'b1, 32'h301, 32'h0, 32'h0000F000, 32'h0, 32'h000000F0, 1'b0, 2);

      // Aligned half and byte stores
      push_beat(32'h400, 1'b1, 4'b1100, 32'hBEEF0000, 1'b1);
      issue(1'b1, 2'b01, 1'b0, 32'h402, 32'h0000BEEF, 32'h0, 32'h0, 32'h0, 1'b0, 2);
      push_beat(32'h500, 1'b1, 4'b0010, 32'h0000AB00, 1'b1);
      issue(1'b1, 2'b00, 1'b0, 32'h501, 32'h000000AB, 32'h0, 32'h0, 32'h0, 1'b0, 2);

      // Size encoding 11 behaves as a word
      push_beat(32'h700, 1'b0, 4'b0000, 32'h0, 1'b0);
      issue(1'b0, 2'b11, 1'b1, 32'h700, 32'h0, 32'h87654321, 32'h0, 32'h87654321, 1'b0, 2);

`ifdef MISALIGN_TRAP_EN
      // Crossing accesses trap without touching the bus
      issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
      issue(1'b1, 2'b01, 1'b0, 32'h103, 32'h11223344, 32'h0, 32'h0, 32'h0, 1'b1, 1);
`else
      // Crossing word store
      push_beat(32'h100, 1'b1, 4'b1000, 32'h44000000, 1'b1);
      push_beat(32'h104, 1'b1, 4'b0111, 32'h00112233, 1'b1);
      issue(1'b1, 2'b10, 1'b0, 32'h103, 32'h11223344, 32'h0, 32'h0, 32'h0, 1'b0, 3);

      // Crossing half load: byte at 0x207 is lane 3 of the low word, 0x208 lane 0 of the high word
      push_beat(32'h204, 1'b0, 4'b0000, 32'h0, 1'b0);
      push_beat(32'h208, 1'b0, 4'b0000, 32'h0, 1'b0);
      issue(1'b0, 2'b01, 1'b0, 32'h207, 32'h0, 32'h80123456, 32'h789ABCFF, 32'hFFFFFF80, 1'b0, 3);

      // Same unsigned, with the high beat held off for 3 cycles
      hold_beat = 1; hold_n = 3;
      push_beat(32'h204, 1'b0, 4'b0000, 32'h0, 1'b0);
      push_beat(32'h208, 1'b0, 4'b0000, 32'h0, 1'b0);
      issue(1'b0, 2'b01, 1'b1, 32'h207, 32'h0, 32'h80123456, 32'h789ABCFF, 32'h0000FF80, 1'b0, 6);
      hold_n = 0;

      // Crossing half load with negative upper byte
      push_beat(32'h204, 1'b0, 4'b0000, 32'h0, 1'b0);
      push_beat(32'h208, 1'b0, 4'b0000, 32'h0, 1'b0);
      issue(1'b0, 2'b01, 1'b0, 32'h207, 32'h0, 32'hFF000000, 32'h00000080, 32'hFFFF80FF, 1'b0, 3);

      // Crossing word load
      push_beat(32'h600, 1'b0, 4'b0000, 32'h0, 1'b0);
      push_beat(32'h604, 1'b0, 4'b0000, 32'h0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h601, 32'h0, 32'hCCBBAA99, 32'h112233DD, 32'hDDCCBBAA, 1'b0, 3);

      // Store at top of memory wraps beat1 to 0; reset while beat1 is stalled
      push_beat(32'hFFFFFFFC, 1'b1, 4'b1100, 32'hC3D40000, 1'b1);
      push_beat(32'h00000000, 1'b1, 4'b0011, 32'h0000A1B2, 1'b1);
      hold_beat = 1; hold_n = 1000;
      @(negedge clk);
      req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
      req_addr_i = 32'hFFFFFFFE; req_wdata_i = 32'hA1B2C3D4; req_valid_i = 1'b1;
      #1 chk("stall_on_request", 32'(stall_o), 32'd1);
      repeat (4) @(negedge clk);
      chk("beat1_pending", 32'(beat_q.size()), 32'd1);
      reset_n = 1'b0;
      req_valid_i = 1'b0;
      @(negedge clk);
      #2;
      chk("abort_mem_valid", 32'(mem_valid_o), 32'd0);
      chk("abort_stall", 32'(stall_o), 32'd0);
      chk("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
      beat_q.delete();
      hold_n = 0;
      reset_n = 1'b1;
`endif

      // Normal operation after everything above
      push_beat(32'h100, 1'b0, 4'b0000, 32'h0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0BADF00D, 32'h0, 32'h0BADF00D, 1'b0, 2);

      for (int i = 0; i < 50; i++) begin
         if (beat_q.size() == 0 && rsp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("beats_drained", 32'(beat_q.size()), 32'd0);
      chk("rsps_drained", 32'(rsp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
